nand_phy_ctl_io_sync: RTL and testbench

- Parametrised NAND control-pin IO stage for half of a NAND package (x8 DQ interface).
- Output path: pipelines the controller-side CLE/ALE/WE#/WP#/CE# through a configurable register depth into IOB flops, with defined safe reset values.
- Input path: brings the asynchronous R/B# pins into clk0 through a multi-stage synchroniser and a per-pin glitch filter, and emits one-cycle ready/busy edge pulses to the controller.
- Sits between the NAND controller FSM and the package pins, alongside the DQ PHY.

---
 rtl/nand_phy_ctl_io_sync_if.sv | 31 +++
 rtl/nand_phy_ctl_io_sync.sv | 109 ++++++++++
 tb/tb_nand_phy_ctl_io_sync.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/nand_phy_ctl_io_sync_if.sv
// NAND control-pin bundle: controller-side controls, package pins and the R/B# status back to the controller.
// master = controller/pin environment, slave = the IO stage.
interface nand_phy_ctl_io_sync_if #(
    parameter int CENS_PER_IO = 2,
    parameter int RBS_PER_IO  = 2
);
    logic                   ctrl_cle;
    logic                   ctrl_ale;
    logic                   ctrl_wrn;
    logic                   ctrl_wpn;
    logic [CENS_PER_IO-1:0] ctrl_cen;
    logic                   cle;
    logic                   ale;
    logic                   wrn;
    logic                   wpn;
    logic [CENS_PER_IO-1:0] cen;
    logic [RBS_PER_IO-1:0]  rb;
    logic [RBS_PER_IO-1:0]  ctrl_rb;
    logic [RBS_PER_IO-1:0]  ctrl_rb_rise;
    logic [RBS_PER_IO-1:0]  ctrl_rb_fall;

    modport master (
        output ctrl_cle, ctrl_ale, ctrl_wrn, ctrl_wpn, ctrl_cen, rb,
        input  cle, ale, wrn, wpn, cen, ctrl_rb, ctrl_rb_rise, ctrl_rb_fall
    );

    modport slave (
        input  ctrl_cle, ctrl_ale, ctrl_wrn, ctrl_wpn, ctrl_cen, rb,
        output cle, ale, wrn, wpn, cen, ctrl_rb, ctrl_rb_rise, ctrl_rb_fall
    );
endinterface

// File: rtl/nand_phy_ctl_io_sync.sv
// NAND control-pin IO stage: registered CLE/ALE/WE#/WP#/CE# outputs and synchronised, glitch-filtered R/B# inputs.
// Latency: pins = ctrl_* delayed OUT_PIPE edges; R/B# = RB_SYNC_STAGES + RB_FILTER_CYCLES edges. No backpressure.
module nand_phy_ctl_io_sync #(
    parameter int CENS_PER_IO      = 2,
    parameter int RBS_PER_IO       = 2,
    parameter int OUT_PIPE         = 1,
    parameter int RB_SYNC_STAGES   = 2,
    parameter int RB_FILTER_CYCLES = 4
) (
    input  logic                    clk0,
    input  logic                    rst0_n,
    nand_phy_ctl_io_sync_if.slave   io
);
    typedef struct packed {
        logic                   cle;
        logic                   ale;
        logic                   wrn;
        logic                   wpn;
        logic [CENS_PER_IO-1:0] cen;
    } ctl_t;

    // Safe pin state: no command/address latch, no write strobe, write-protected, all chips deselected.
    localparam ctl_t CTL_RST = '{cle: 1'b0, ale: 1'b0, wrn: 1'b1, wpn: 1'b0, cen: {CENS_PER_IO{1'b1}}};

    localparam int CW = $clog2(RB_FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RB_FILTER_CYCLES - 1);

    ctl_t                  pipe_q [OUT_PIPE];
    ctl_t                  pipe_d [OUT_PIPE];
    logic [RBS_PER_IO-1:0] sync_q [RB_SYNC_STAGES];
    logic [RBS_PER_IO-1:0] sync_d [RB_SYNC_STAGES];
    logic [CW-1:0]         cnt_q  [RBS_PER_IO];
    logic [CW-1:0]         cnt_d  [RBS_PER_IO];
    logic [RBS_PER_IO-1:0] rb_q, rb_d;
    logic [RBS_PER_IO-1:0] rise_q, rise_d;
    logic [RBS_PER_IO-1:0] fall_q, fall_d;
    logic [RBS_PER_IO-1:0] rb_s;

    // Last pipe entry drives the pins directly and is intended for the IOB flops.
    always_comb begin
        pipe_d[0] = '{cle: io.ctrl_cle, ale: io.ctrl_ale, wrn: io.ctrl_wrn,
                      wpn: io.ctrl_wpn, cen: io.ctrl_cen};
        for (int i = 1; i < OUT_PIPE; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        sync_d[0] = io.rb;
        for (int i = 1; i < RB_SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign rb_s = sync_q[RB_SYNC_STAGES-1];

    // A new level is accepted only after persisting; returning to the accepted level drops the count.
    always_comb begin
        rb_d   = rb_q;
        rise_d = '0;
        fall_d = '0;
        cnt_d  = cnt_q;
        for (int b = 0; b < RBS_PER_IO; b++) begin
            if (rb_s[b] == rb_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == CNT_LAST) begin
                rb_d[b]   = rb_s[b];
                cnt_d[b]  = '0;
                rise_d[b] = rb_s[b];
                fall_d[b] = ~rb_s[b];
            end else begin
                cnt_d[b] = cnt_q[b] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            for (int i = 0; i < OUT_PIPE; i++) begin
                pipe_q[i] <= CTL_RST;
            end
            for (int i = 0; i < RB_SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            for (int b = 0; b < RBS_PER_IO; b++) begin
                cnt_q[b] <= '0;
            end
            rb_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            pipe_q <= pipe_d;
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            rb_q   <= rb_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign io.cle          = pipe_q[OUT_PIPE-1].cle;
    assign io.ale          = pipe_q[OUT_PIPE-1].ale;
    assign io.wrn          = pipe_q[OUT_PIPE-1].wrn;
    assign io.wpn          = pipe_q[OUT_PIPE-1].wpn;
    assign io.cen          = pipe_q[OUT_PIPE-1].cen;
    assign io.ctrl_rb      = rb_q;
    assign io.ctrl_rb_rise = rise_q;
    assign io.ctrl_rb_fall = fall_q;
endmodule

// File: tb/tb_nand_phy_ctl_io_sync.sv
// Directed bench for nand_phy_ctl_io_sync: three parameter sets share clk0/rst0_n,
// each driven through its own interface instance with hand-derived expected values.
module tb_nand_phy_ctl_io_sync;
    logic clk0;
    logic rst0_n;
    int   n_chk;
    int   n_err;

    nand_phy_ctl_io_sync_if #(.CENS_PER_IO(2), .RBS_PER_IO(2)) if_def ();
    nand_phy_ctl_io_sync_if #(.CENS_PER_IO(2), .RBS_PER_IO(2)) if_p3 ();
    nand_phy_ctl_io_sync_if #(.CENS_PER_IO(2), .RBS_PER_IO(2)) if_f1 ();

    nand_phy_ctl_io_sync #(
        .CENS_PER_IO(2), .RBS_PER_IO(2), .OUT_PIPE(1), .RB_SYNC_STAGES(2), .RB_FILTER_CYCLES(4)
    ) u_def (.clk0(clk0), .rst0_n(rst0_n), .io(if_def));

    nand_phy_ctl_io_sync #(
        .CENS_PER_IO(2), .RBS_PER_IO(2), .OUT_PIPE(3), .RB_SYNC_STAGES(2), .RB_FILTER_CYCLES(4)
    ) u_p3 (.clk0(clk0), .rst0_n(rst0_n), .io(if_p3));

    nand_phy_ctl_io_sync #(
        .CENS_PER_IO(2), .RBS_PER_IO(2), .OUT_PIPE(2), .RB_SYNC_STAGES(3), .RB_FILTER_CYCLES(1)
    ) u_f1 (.clk0(clk0), .rst0_n(rst0_n), .io(if_f1));

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge; outputs are then sampled and inputs driven 1 time unit later.
    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int nfall;
    int nrise;
    logic seen_fall;
    logic seen_low;

    initial begin
        n_chk  = 0;
        n_err  = 0;
        rst0_n = 1'b1;
        // Non-reset values on the controller side so the reset checks are meaningful.
        if_def.ctrl_cle = 1'b1; if_def.ctrl_ale = 1'b1; if_def.ctrl_wrn = 1'b0;
        if_def.ctrl_wpn = 1'b1; if_def.ctrl_cen = 2'b00; if_def.rb = 2'b11;
        if_p3.ctrl_cle = 1'b1; if_p3.ctrl_ale = 1'b1; if_p3.ctrl_wrn = 1'b0;
        if_p3.ctrl_wpn = 1'b1; if_p3.ctrl_cen = 2'b00; if_p3.rb = 2'b00;
        if_f1.ctrl_cle = 1'b0; if_f1.ctrl_ale = 1'b0; if_f1.ctrl_wrn = 1'b1;
        if_f1.ctrl_wpn = 1'b0; if_f1.ctrl_cen = 2'b11; if_f1.rb = 2'b00;
        #1 rst0_n = 1'b0;
        tick_n(3);

        // Reset values
        chk("rst_cle", 32'(if_def.cle), 0);
        chk("rst_ale", 32'(if_def.ale), 0);
        chk("rst_wrn", 32'(if_def.wrn), 1);
        chk("rst_wpn", 32'(if_def.wpn), 0);
        chk("rst_cen", 32'(if_def.cen), 3);
        chk("rst_ctrl_rb", 32'(if_def.ctrl_rb), 0);
        chk("rst_rise", 32'(if_def.ctrl_rb_rise), 0);
        chk("rst_fall", 32'(if_def.ctrl_rb_fall), 0);
        chk("rst_p3_wrn", 32'(if_p3.wrn), 1);
        chk("rst_p3_cen", 32'(if_p3.cen), 3);

        // Release with rb=11 held: filtered ready on the 6th edge, one-cycle rise
        if_def.ctrl_cle = 1'b0; if_def.ctrl_ale = 1'b0; if_def.ctrl_wrn = 1'b1;
        if_def.ctrl_wpn = 1'b1; if_def.ctrl_cen = 2'b11;
        if_p3.ctrl_cle = 1'b0; if_p3.ctrl_ale = 1'b0; if_p3.ctrl_wrn = 1'b1;
        if_p3.ctrl_wpn = 1'b1; if_p3.ctrl_cen = 2'b11;
        rst0_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk($sformatf("rel_rb_e%0d", e), 32'(if_def.ctrl_rb), (e >= 6) ? 3 : 0);
            chk($sformatf("rel_rise_e%0d", e), 32'(if_def.ctrl_rb_rise), (e == 6) ? 3 : 0);
        end
        chk("rel_wpn", 32'(if_def.wpn), 1);

        // OUT_PIPE=1 latency on CLE
        if_def.ctrl_cle = 1'b1;
        tick();
        chk("p1_cle_hi", 32'(if_def.cle), 1);
        if_def.ctrl_cle = 1'b0;
        tick();
        chk("p1_cle_lo", 32'(if_def.cle), 0);

        // OUT_PIPE=3: one-cycle WE# low with CE#=10 appears exactly 3 edges later
        if_p3.ctrl_wrn = 1'b0;
        if_p3.ctrl_cen = 2'b10;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) begin
                if_p3.ctrl_wrn = 1'b1;
                if_p3.ctrl_cen = 2'b11;
            end
            chk($sformatf("p3_wrn_k%0d", k), 32'(if_p3.wrn), (k == 3) ? 0 : 1);
            chk($sformatf("p3_cen_k%0d", k), 32'(if_p3.cen), (k == 3) ? 2 : 3);
            chk($sformatf("p3_cle_k%0d", k), 32'(if_p3.cle), 0);
        end

        // Glitch of 3 cycles on rb[0] is rejected
        seen_fall = 1'b0;
        seen_low  = 1'b0;
        if_def.rb = 2'b10;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 3) if_def.rb = 2'b11;
            seen_fall = seen_fall | if_def.ctrl_rb_fall[0];
            seen_low  = seen_low | ~if_def.ctrl_rb[0];
        end
        chk("g3_fall_seen", 32'(seen_fall), 0);
        chk("g3_low_seen", 32'(seen_low), 0);

        // Low of 4 cycles on rb[0] is accepted on edge 6, then recovers
        nfall = 0;
        if_def.rb = 2'b10;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 4) if_def.rb = 2'b11;
            nfall += int'(if_def.ctrl_rb_fall[0]);
            if (e == 5) chk("g4_rb0_e5", 32'(if_def.ctrl_rb[0]), 1);
            if (e == 6) begin
                chk("g4_rb0_e6", 32'(if_def.ctrl_rb[0]), 0);
                chk("g4_fall_e6", 32'(if_def.ctrl_rb_fall), 1);
            end
            if (e == 7) chk("g4_fall_e7", 32'(if_def.ctrl_rb_fall), 0);
        end
        chk("g4_nfall", 32'(nfall), 1);
        chk("g4_rb_back", 32'(if_def.ctrl_rb), 3);

        // Independent bits: rb[1] busy first, then swap both on the same edge
        if_def.rb = 2'b01;
        tick_n(10);
        chk("ind_pre", 32'(if_def.ctrl_rb), 1);
        if_def.rb = 2'b10;
        nfall = 0;
        nrise = 0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            nfall += int'(if_def.ctrl_rb_fall[0]);
            nrise += int'(if_def.ctrl_rb_rise[1]);
            if (e == 6) begin
                chk("ind_rb_e6", 32'(if_def.ctrl_rb), 2);
                chk("ind_fall_e6", 32'(if_def.ctrl_rb_fall), 1);
                chk("ind_rise_e6", 32'(if_def.ctrl_rb_rise), 2);
            end
        end
        chk("ind_nfall0", 32'(nfall), 1);
        chk("ind_nrise1", 32'(nrise), 1);

        // Reset mid-operation: CLE in flight, rb[0] filter count pending
        if_def.rb = 2'b11;
        tick_n(2);
        if_def.ctrl_cle = 1'b1;
        if_p3.ctrl_cle  = 1'b1;
        tick();
        chk("mid_cle_pre", 32'(if_def.cle), 1);
        chk("mid_p3_cle_pre", 32'(if_p3.cle), 0);
        #2 rst0_n = 1'b0;
        #1;
        chk("mid_cle_now", 32'(if_def.cle), 0);
        chk("mid_rb_now", 32'(if_def.ctrl_rb), 0);
        chk("mid_rise_now", 32'(if_def.ctrl_rb_rise), 0);
        chk("mid_fall_now", 32'(if_def.ctrl_rb_fall), 0);
        tick_n(2);
        chk("mid_fall_hold", 32'(if_def.ctrl_rb_fall), 0);
        if_def.ctrl_cle = 1'b0;
        if_p3.ctrl_cle  = 1'b0;
        rst0_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk($sformatf("mid_p3_cle_e%0d", e), 32'(if_p3.cle), 0);
            if (e == 5) chk("mid_rb_e5", 32'(if_def.ctrl_rb), 0);
            if (e == 6) begin
                chk("mid_rb_e6", 32'(if_def.ctrl_rb), 3);
                chk("mid_rise_e6", 32'(if_def.ctrl_rb_rise), 3);
            end
            if (e == 7) chk("mid_rise_e7", 32'(if_def.ctrl_rb_rise), 0);
        end

        // RB_FILTER_CYCLES=1, RB_SYNC_STAGES=3, OUT_PIPE=2
        if_f1.rb = 2'b10;
        if_f1.ctrl_wpn = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk($sformatf("f1_rb1_e%0d", e), 32'(if_f1.ctrl_rb[1]), (e >= 4) ? 1 : 0);
            chk($sformatf("f1_rise_e%0d", e), 32'(if_f1.ctrl_rb_rise), (e == 4) ? 2 : 0);
            if (e <= 2) chk($sformatf("f1_wpn_e%0d", e), 32'(if_f1.wpn), (e == 2) ? 1 : 0);
        end
        if_f1.rb = 2'b00;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 1) if_f1.rb = 2'b10;
            if (e >= 3) begin
                chk($sformatf("f1g_rb1_e%0d", e), 32'(if_f1.ctrl_rb[1]), (e == 4) ? 0 : 1);
                chk($sformatf("f1g_fall_e%0d", e), 32'(if_f1.ctrl_rb_fall), (e == 4) ? 2 : 0);
                chk($sformatf("f1g_rise_e%0d", e), 32'(if_f1.ctrl_rb_rise), (e == 5) ? 2 : 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
